seq_detector: RTL and testbench

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_detector.sv | 130 +++++++++++++
 tb/tb_seq_detector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//   Serial bit-pattern detector with a loadable pattern register and an
//   optional saturating match counter.
//
//   Each accepted bit (a_valid=1) is shifted into a WIDTH-bit history
//   register. A fill counter tracks how many bits the history holds. When the
//   history is full and equals the pattern register, the FSM enters MATCH.
//   y is high only while the FSM is in MATCH, so it pulses for one cycle.
//
//   Parameters
//     WIDTH   : pattern length in bits (2..16)
//     PATTERN : reset value of the pattern register (MSB = first bit)
//     OVERLAP : 1 = matches may share bits, 0 = each match needs fresh bits
//     CNT_W   : width of match_count
//
//   Ports
//     clk         : clock, rising edge
//     reset       : asynchronous active-high reset
//     a           : serial data bit
//     a_valid     : a is sampled only when high
//     pat_load    : load pat_in into the pattern register, restart filling
//     pat_in      : new pattern (MSB = first bit)
//     y           : registered match pulse
//     match_count : saturating match count
//
//   Build option
//     SEQDET_COUNT_EN : when defined, the match counter is built; otherwise
//                       match_count is tied to zero.
// ---------------------------------------------------------------------------
module seq_detector #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             a_valid,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  localparam int             FW   = $clog2(WIDTH + 1);
  localparam logic [FW-1:0]  FULL = FW'(WIDTH);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    MATCH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hist;
  logic [WIDTH-1:0] pat;
  logic [FW-1:0]    fill;

  logic [WIDTH-1:0] hist_nxt;
  logic [FW-1:0]    fill_nxt;
  logic             hit;

  // Post-shift view of the history; a match is judged on this view so the
  // matching bit itself completes the pattern.
  always_comb begin
    hist_nxt = {hist[WIDTH-2:0], a};
    fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
    hit      = a_valid && (fill_nxt == FULL) && (hist_nxt == pat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      y     <= 1'b0;
      fill  <= '0;
      hist  <= '0;
      pat   <= PATTERN;
    end else if (pat_load) begin
      // A bit presented alongside pat_load is dropped on purpose.
      pat   <= pat_in;
      fill  <= '0;
      hist  <= '0;
      state <= FILL;
      y     <= 1'b0;
    end else if (a_valid) begin
      hist <= hist_nxt;
      if (hit) begin
        state <= MATCH;
        y     <= 1'b1;
        // Without overlap, forget the matched bits so they cannot be reused.
        fill  <= (OVERLAP != 0) ? FULL : '0;
      end else begin
        fill  <= fill_nxt;
        state <= (fill_nxt == FULL) ? ARMED : FILL;
        y     <= 1'b0;
      end
    end else begin
      // Idle edge: history holds, but a MATCH pulse still ends here.
      y <= 1'b0;
      if (state == MATCH) begin
        state <= (fill == FULL) ? ARMED : FILL;
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (pat_load) begin
      cnt <= '0;
    end else if (hit) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_detector
//   Scoreboard bench for seq_detector. Three instances share one stimulus
//   stream:
//     u_ov  : defaults (PATTERN=1011, OVERLAP=1, CNT_W=8)
//     u_nov : OVERLAP=0
//     u_sat : PATTERN=1111, CNT_W=2
//   A behavioural reference model computes the expected y and match_count of
//   each instance when stimulus is driven; the expectation is queued and
//   popped for comparison after the clock edge.
// ---------------------------------------------------------------------------
module tb_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       a;
  logic       a_valid;
  logic       pat_load;
  logic [3:0] pat_in;

  logic       y_ov, y_nov, y_sat;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_sat;

  always #5 clk = ~clk;

  seq_detector u_ov (
    .clk(clk), .reset(reset), .a(a), .a_valid(a_valid), .pat_load(pat_load),
    .pat_in(pat_in), .y(y_ov), .match_count(cnt_ov)
  );

  seq_detector #(.OVERLAP(0)) u_nov (
    .clk(clk), .reset(reset), .a(a), .a_valid(a_valid), .pat_load(pat_load),
    .pat_in(pat_in), .y(y_nov), .match_count(cnt_nov)
  );

  seq_detector #(.PATTERN(4'b1111), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .a(a), .a_valid(a_valid), .pat_load(pat_load),
    .pat_in(pat_in), .y(y_sat), .match_count(cnt_sat)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, index 0=u_ov, 1=u_nov, 2=u_sat
  logic [3:0] m_hist [3];
  logic [3:0] m_pat  [3];
  int         m_fill [3];
  int         m_cnt  [3];
  int         m_ey   [3];
  int         m_ec   [3];
  int         m_ov   [3] = '{1, 0, 1};
  int         m_max  [3] = '{255, 255, 3};
  logic [3:0] m_rpat [3] = '{4'b1011, 4'b1011, 4'b1111};

  typedef struct {
    string tag;
    int    y0, y1, y2;
    int    c0, c1, c2;
  } exp_t;

  exp_t sb [$];

  function automatic int cnt_view(input int c);
`ifdef SEQDET_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = '0;
      m_pat[i]  = m_rpat[i];
      m_fill[i] = 0;
      m_cnt[i]  = 0;
      m_ey[i]   = 0;
      m_ec[i]   = 0;
    end
  endtask

  task automatic model_step(input logic ai, input logic vi, input logic li,
                            input logic [3:0] pi);
    for (int i = 0; i < 3; i++) begin
      m_ey[i] = 0;
      if (li) begin
        m_pat[i]  = pi;
        m_hist[i] = '0;
        m_fill[i] = 0;
        m_cnt[i]  = 0;
      end else if (vi) begin
        m_hist[i] = {m_hist[i][2:0], ai};
        if (m_fill[i] < 4) m_fill[i]++;
        if (m_fill[i] == 4 && m_hist[i] == m_pat[i]) begin
          m_ey[i] = 1;
          if (m_cnt[i] < m_max[i]) m_cnt[i]++;
          if (m_ov[i] == 0) m_fill[i] = 0;
        end
      end
      m_ec[i] = cnt_view(m_cnt[i]);
    end
  endtask

  task automatic check_now(input string tag);
    check({tag, ".y_ov"},  int'(y_ov),    m_ey[0]);
    check({tag, ".y_nov"}, int'(y_nov),   m_ey[1]);
    check({tag, ".y_sat"}, int'(y_sat),   m_ey[2]);
    check({tag, ".c_ov"},  int'(cnt_ov),  m_ec[0]);
    check({tag, ".c_nov"}, int'(cnt_nov), m_ec[1]);
    check({tag, ".c_sat"}, int'(cnt_sat), m_ec[2]);
  endtask

  // Called just after a rising edge; drives one cycle of stimulus.
  task automatic step(input logic ai, input logic vi, input logic li,
                      input logic [3:0] pi, input string tag);
    exp_t e;
    exp_t got;
    a        = ai;
    a_valid  = vi;
    pat_load = li;
    pat_in   = pi;
    model_step(ai, vi, li, pi);
    e.tag = tag;
    e.y0 = m_ey[0]; e.y1 = m_ey[1]; e.y2 = m_ey[2];
    e.c0 = m_ec[0]; e.c1 = m_ec[1]; e.c2 = m_ec[2];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      check({got.tag, ".y_ov"},  int'(y_ov),    got.y0);
      check({got.tag, ".y_nov"}, int'(y_nov),   got.y1);
      check({got.tag, ".y_sat"}, int'(y_sat),   got.y2);
      check({got.tag, ".c_ov"},  int'(cnt_ov),  got.c0);
      check({got.tag, ".c_nov"}, int'(cnt_nov), got.c1);
      check({got.tag, ".c_sat"}, int'(cnt_sat), got.c2);
    end
  endtask

  task automatic bits(input logic [15:0] v, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, 1'b0, 4'h0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, tag);
  endtask

  // Asserts reset mid-cycle, checks it acts before any clock edge, holds it
  // for the given number of edges, then releases between edges.
  task automatic do_reset(input int cyc, input string tag);
    reset    = 1'b1;
    a_valid  = 1'b0;
    pat_load = 1'b0;
    model_reset();
    #2;
    check_now({tag, ".async"});
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      check_now({tag, ".hold"});
    end
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    a        = 1'b0;
    a_valid  = 1'b0;
    pat_load = 1'b0;
    pat_in   = 4'h0;
    model_reset();
    @(posedge clk);
    #1;

    do_reset(2, "rst");
    idle(4, "rst_idle");

    // 1011011 stream: overlap detects twice, non-overlap once.
    do_reset(1, "r1");
    bits(16'b1011011, 7, "ovl");
    idle(2, "ovl_idle");

    // Bits separated by idle cycles.
    do_reset(1, "r2");
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] v;
      v = 4'b1011;
      step(v[i], 1'b1, 1'b0, 4'h0, "gap_bit");
      idle(3, "gap_idle");
    end

    // Pattern load coinciding with the completing bit.
    do_reset(1, "r3");
    bits(16'b101, 3, "ld_pre");
    step(1'b1, 1'b1, 1'b1, 4'b0110, "ld_edge");
    bits(16'b0110, 4, "ld_new");
    idle(2, "ld_idle");

    // Back-to-back ones: u_sat counter saturates at 3.
    do_reset(1, "r4");
    bits(16'hFF, 8, "sat");
    idle(2, "sat_idle");

    // Reset mid-sequence discards the partial history.
    do_reset(1, "r5");
    bits(16'b101, 3, "mid_pre");
    do_reset(1, "r6");
    bits(16'b1011, 4, "mid_post");
    idle(2, "mid_idle");

    // Random traffic with occasional pattern loads.
    do_reset(1, "r7");
    for (int i = 0; i < 120; i++) begin
      logic ai, vi, li;
      logic [3:0] pi;
      ai = ($urandom_range(0, 3) != 0);
      vi = ($urandom_range(0, 4) != 0);
      li = ($urandom_range(0, 24) == 0);
      pi = 4'($urandom_range(0, 15));
      step(ai, vi, li, pi, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
